// File: rtl/stoch_dot_sched.sv
// rtl/stoch_dot_sched.sv - row scheduler for a shared stochastic dot-product datapath
// Optional macro STOCH_DOT_SCHED_CONT_EN: wrap from the last row back to row 0 instead of idling.
module stoch_dot_sched #(
  parameter  int NUM_ROWS = 4,
  parameter  int WINDOW   = 256,
  localparam int RW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW       = $clog2(WINDOW + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          start,
  output logic          busy,
  output logic [RW-1:0] row_sel,
  output logic          dp_clr,
  output logic          dp_en,
  input  logic          dp_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_row,
  output logic [CW-1:0] res_count,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_OUT} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] win_q, win_d;
  logic          done_q, done_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    win_d   = win_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      S_CLEAR: begin
        acc_d   = '0;
        win_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // At most WINDOW increments, so the CW-bit accumulator cannot wrap
        acc_d = acc_q + CW'(dp_y);
        win_d = win_q + CW'(1);
        if (win_q == WIN_LAST) state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          if (row_q == LAST_ROW) begin
            done_d = 1'b1;
`ifdef STOCH_DOT_SCHED_CONT_EN
            state_d = S_CLEAR;
            row_d   = '0;
`else
            state_d = S_IDLE;
`endif
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_CLEAR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    dp_clr    = 1'b0;
    dp_en     = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy   = 1'b1;
        dp_clr = 1'b1;
      end
      S_RUN: begin
        busy  = 1'b1;
        dp_en = 1'b1;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign row_sel   = row_q;
  assign res_row   = row_q;
  assign res_count = acc_q;
  assign done      = done_q;

endmodule

// File: doc/stoch_dot_sched.md
STOCH_DOT_SCHED -- requirements
Module: stoch_dot_sched

Interface
REQ-001: Parameter NUM_ROWS, default 4: number of matrix rows sequenced through the shared stochastic dot-product datapath; minimum 1.
REQ-002: Parameter WINDOW, default 256: bitstream cycles evaluated per row; minimum 1.
REQ-003: Derived widths: RW = max(1, $clog2(NUM_ROWS)); CW = $clog2(WINDOW+1).
REQ-004: CLK  input  1  clock; all state changes on rising edge.
REQ-005: nRST  input  1  reset, synchronous, active-low.
REQ-006: start  input  1  begin one pass over all rows; sampled only in IDLE.
REQ-007: busy  output  1  high in every state except IDLE.
REQ-008: row_sel  output  RW  row index driven to the datapath operand mux.
REQ-009: dp_clr  output  1  one-cycle clear of the datapath's internal signed counter.
REQ-010: dp_en  output  1  datapath evaluation enable; high for exactly WINDOW cycles per row.
REQ-011: dp_y  input  1  datapath output bit for the current cycle.
REQ-012: res_valid  output  1  row result available.
REQ-013: res_ready  input  1  consumer accepts result.
REQ-014: res_row  output  RW  row index of the presented result.
REQ-015: res_count  output  CW  number of dp_y ones observed over the row's window.
REQ-016: done  output  1  one-cycle pulse after the last row's result is accepted.

Function
REQ-017: FSM states IDLE, CLEAR, RUN, OUT; encoding free.
REQ-018: IDLE: start=1 -> CLEAR with row index 0; otherwise stay; all outputs except row_sel/res_row/res_count low.
REQ-019: CLEAR: lasts exactly one cycle; dp_clr=1, dp_en=0; window counter and ones accumulator loaded to 0; next state RUN.
REQ-020: RUN: dp_en=1; each cycle accumulator += dp_y; window counter increments; after the WINDOW-th RUN cycle -> OUT.
REQ-021: Accumulator is CW bits and never wraps (max value WINDOW).
REQ-022: OUT: res_valid=1, res_count and res_row stable while res_valid=1 and res_ready=0; dp_en=0.
REQ-023: Transfer occurs on a cycle with res_valid=1 and res_ready=1; res_valid deasserts the following cycle unless a new result is presented.
REQ-024: On transfer, row index < NUM_ROWS-1 -> row index +1, go CLEAR; row index = NUM_ROWS-1 -> IDLE with done=1 for that one cycle following transfer.
REQ-025: row_sel equals the current row index in CLEAR, RUN, OUT; it is held (not changed) in IDLE.
REQ-026: Latency: start sampled at edge k -> CLEAR during cycle k+1, RUN cycles k+2..k+1+WINDOW, res_valid first high at cycle k+2+WINDOW.
REQ-027: With res_ready held high, per-row period is WINDOW+2 cycles; full pass NUM_ROWS*(WINDOW+2) cycles from first CLEAR to done.
REQ-028: start asserted while busy=1 is ignored (not queued).
REQ-029: dp_y is ignored in every state except RUN.

Reset
REQ-030: nRST=0 at a rising edge forces IDLE, row index 0, accumulator 0, window counter 0, done=0, res_valid=0, dp_en=0, dp_clr=0, from any state including mid-RUN or OUT with pending result (result discarded).
REQ-031: The cycle after reset release, start is honoured normally.

Configuration
REQ-032: Macro STOCH_DOT_SCHED_CONT_EN: when defined, the transfer of row NUM_ROWS-1 goes to CLEAR with row index 0 (continuous operation, done still pulses once per pass); leaving continuous mode requires nRST.
REQ-033: Without STOCH_DOT_SCHED_CONT_EN, behaviour is exactly REQ-024 (single pass, return to IDLE).

Verification (NUM_ROWS=4, WINDOW=16)
REQ-034: start pulse, dp_y=1 constantly, res_ready=1 -> four results rows 0..3, res_count=16 each, res_valid at cycle k+18 first, done at cycle after 4th transfer, 72 cycles CLEAR-to-done.
REQ-035: dp_y alternating 1/0 starting with 1 in first RUN cycle -> res_count=8 per row; dp_y=0 -> res_count=0.
REQ-036: res_ready low for 5 cycles in OUT of row 1 -> res_valid, res_row=1, res_count stable for all 5 cycles; no dp_en; row 2 CLEAR after acceptance.
REQ-037: start re-pulsed during RUN of row 2 -> ignored; exactly one done; nRST=0 in RUN of row 1 -> IDLE, busy=0, res_valid=0 next cycle.
REQ-038: With STOCH_DOT_SCHED_CONT_EN, res_ready=1 -> row sequence 0,1,2,3,0,1..., done pulses every 72 cycles, busy never drops.
